// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants shared with the alu, driver FSM states, and the request type
package alu_pkg;
  localparam int OPC_WIDTH = 3;
  localparam int ALU_WIDTH = 4;
  localparam logic [OPC_WIDTH-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_WIDTH-1:0] OP_SUB = 3'b001;
  localparam logic [OPC_WIDTH-1:0] OP_AND = 3'b010;
  localparam logic [OPC_WIDTH-1:0] OP_OR  = 3'b011;
  localparam logic [OPC_WIDTH-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_WIDTH-1:0] OP_NOT = 3'b101;
  localparam logic [OPC_WIDTH-1:0] OP_SHL = 3'b110;
  localparam logic [OPC_WIDTH-1:0] OP_SHR = 3'b111;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} drv_state_t;
  typedef struct packed {
    logic [OPC_WIDTH-1:0] opcode;
    logic [ALU_WIDTH-1:0] op1;
    logic [ALU_WIDTH-1:0] op2;
  } alu_req_t;
endpackage

// File: rtl/alu_op_driver_if.sv
// alu_op_driver_if: request, ALU drive and response signals of the op driver
//   req_*  : valid/ready request channel (opcode, op1, op2)
//   alu_*  : operands driven into the ALU and its result/carry
//   rsp_*  : valid/ready response channel (opcode tag, result, carry)
//   master : the driver side; slave : the sequencer/ALU environment side
interface alu_op_driver_if import alu_pkg::*; #(
  parameter int W = ALU_WIDTH,
  parameter int OPC_W = OPC_WIDTH
);
  logic             req_valid;
  logic             req_ready;
  logic [OPC_W-1:0] req_opcode;
  logic [W-1:0]     req_op1;
  logic [W-1:0]     req_op2;
  logic [OPC_W-1:0] alu_opcode;
  logic [W-1:0]     alu_op1;
  logic [W-1:0]     alu_op2;
  logic [W-1:0]     alu_result;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OPC_W-1:0] rsp_opcode;
  logic [W-1:0]     rsp_result;
  logic             rsp_carry;
  modport master (
    input  req_valid, req_opcode, req_op1, req_op2, alu_result, alu_carry, rsp_ready,
    output req_ready, alu_opcode, alu_op1, alu_op2, rsp_valid, rsp_opcode, rsp_result, rsp_carry
  );
  modport slave (
    output req_valid, req_opcode, req_op1, req_op2, alu_result, alu_carry, rsp_ready,
    input  req_ready, alu_opcode, alu_op1, alu_op2, rsp_valid, rsp_opcode, rsp_result, rsp_carry
  );
endinterface

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: synchronous first-word-fall-through FIFO with async active-high reset
//   clk, rst         : clock, asynchronous reset
//   push_i, wdata_i  : write request and data (ignored when full)
//   pop_i, rdata_o   : read request (ignored when empty) and head data
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries
module alu_op_fifo import alu_pkg::*; #(
  parameter int WIDTH = OPC_WIDTH + 2 * ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  // pointers are exactly log2(DEPTH) bits so they wrap without compare logic
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
endmodule

// File: rtl/alu_op_driver.sv
// alu_op_driver: queues ALU op requests, drives them one at a time into the ALU,
// waits ALU_LAT cycles, captures result/carry and returns it on a response channel.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_op_driver_if.master (req_*, alu_*, rsp_* channels)
//   op_count : issued-op counter, present only with ALU_OP_DRIVER_PERF_EN defined
module alu_op_driver import alu_pkg::*; #(
  parameter int W = ALU_WIDTH,
  parameter int OPC_W = OPC_WIDTH,
  parameter int DEPTH = 4,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_driver_if.master    bus
`ifdef ALU_OP_DRIVER_PERF_EN
  ,
  output logic [7:0]         op_count
`endif
);
  localparam int RW = OPC_W + 2 * W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [RW-1:0] head;
  drv_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] alu_opcode_q, alu_opcode_d, rsp_opcode_q, rsp_opcode_d;
  logic [W-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d, rsp_result_q, rsp_result_d;
  logic rsp_carry_q, rsp_carry_d, rsp_valid_q, rsp_valid_d;
  // a full FIFO refuses the push even if the FSM pops in the same cycle
  alu_op_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(bus.req_valid && !fifo_full),
    .wdata_i({bus.req_opcode, bus.req_op1, bus.req_op2}),
    .pop_i(fifo_pop),
    .rdata_o(head),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );
  a_full_count: assert property (@(posedge clk) disable iff (rst) fifo_full == (fifo_count == CW'(DEPTH)));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_op1_d = alu_op1_q;
    alu_op2_d = alu_op2_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d = rsp_carry_q;
    rsp_valid_d = rsp_valid_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE:
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {alu_opcode_d, alu_op1_d, alu_op2_d} = head;
          cnt_d = 4'(ALU_LAT);
          state_d = WAIT;
        end
      // the counter is loaded with ALU_LAT at issue, so reaching 1 marks the edge
      // exactly ALU_LAT cycles after the operands changed
      WAIT:
        if (cnt_q == 4'd1) begin
          rsp_opcode_d = alu_opcode_q;
          rsp_result_d = bus.alu_result;
          rsp_carry_d = bus.alu_carry;
          rsp_valid_d = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q - 4'd1;
      RESP:
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      alu_opcode_q <= '0;
      alu_op1_q <= '0;
      alu_op2_q <= '0;
      rsp_opcode_q <= '0;
      rsp_result_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q <= alu_op1_d;
      alu_op2_q <= alu_op2_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_valid_q <= rsp_valid_d;
    end
  assign bus.req_ready = !fifo_full;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_op1 = alu_op1_q;
  assign bus.alu_op2 = alu_op2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry = rsp_carry_q;
`ifdef ALU_OP_DRIVER_PERF_EN
  logic [7:0] op_count_q;
  // every pop is an IDLE->WAIT issue; 8-bit wrap is intended
  always_ff @(posedge clk or posedge rst)
    if (rst) op_count_q <= '0;
    else op_count_q <= op_count_q + 8'(fifo_pop);
  assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: directed scoreboard bench for alu_op_driver with a latency-accurate ALU model
module tb_alu_op_driver;
  import alu_pkg::*;
  localparam int LAT = 3;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [2:0] opc;
    logic [3:0] res;
    logic       c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int nrsp = 0;
  int cyc = 0;
  int n_iss = 0;
  bit tp_on = 1'b0;
  int iss [16];
  exp_t exp_q [$];
  exp_t e;
  logic [4:0] r;
  logic [10:0] cur_alu;
  logic [10:0] last_alu = '0;
  logic [4:0] pipe [LAT-1];
`ifdef ALU_OP_DRIVER_PERF_EN
  logic [7:0] op_count;
`endif
  alu_op_driver_if #(.W(4), .OPC_W(3)) bus ();
  alu_op_driver #(.W(4), .OPC_W(3), .DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_OP_DRIVER_PERF_EN
    ,
    .op_count(op_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] alu_model(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    return {o[1] ^ b[0], 4'(a + b + 4'(3 * o))};
  endfunction
  // result becomes valid ALU_LAT edges after the operands change; earlier samples see stale data
  always @(posedge clk) begin
    pipe[0] <= alu_model(bus.alu_opcode, bus.alu_op1, bus.alu_op2);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign {bus.alu_carry, bus.alu_result} = pipe[LAT-2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    cur_alu = {bus.alu_opcode, bus.alu_op1, bus.alu_op2};
    if (!rst) begin
      cyc++;
      if (bus.req_valid && bus.req_ready) begin
        r = alu_model(bus.req_opcode, bus.req_op1, bus.req_op2);
        exp_q.push_back('{opc: bus.req_opcode, res: r[3:0], c: r[4]});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_opcode", 32'(bus.rsp_opcode), 32'(e.opc));
          chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
          chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
        end
        nrsp++;
      end
      if (tp_on && cur_alu != last_alu && n_iss < 16) begin
        iss[n_iss] = cyc;
        n_iss++;
      end
    end
    last_alu = cur_alu;
  end
  task automatic push(input alu_req_t q);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_opcode = q.opcode;
    bus.req_op1 = q.op1;
    bus.req_op2 = q.op2;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("push_accepted", 32'(ok), 1);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 0);
  endtask
  initial begin
    int acc, base, seen;
    bus.req_valid = 1'b0;
    bus.req_opcode = '0;
    bus.req_op1 = '0;
    bus.req_op2 = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_alu", 32'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 0);
    chk("reset_rsp", 32'({bus.rsp_opcode, bus.rsp_result, bus.rsp_carry}), 0);
`ifdef ALU_OP_DRIVER_PERF_EN
    chk("reset_op_count", 32'(op_count), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_opcode = 3'b010;
    bus.req_op1 = 4'b1000;
    bus.req_op2 = 4'b0000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("single_alu_before_issue", 32'(bus.alu_op1), 0);
    @(posedge clk);
    #1;
    chk("single_alu_opcode", 32'(bus.alu_opcode), 32'(3'b010));
    chk("single_alu_op1", 32'(bus.alu_op1), 32'(4'b1000));
    chk("single_alu_op2", 32'(bus.alu_op2), 32'(4'b0000));
    acc = 0;
    while (!bus.rsp_valid && acc < 20) begin
      @(posedge clk);
      #1;
      acc++;
    end
    chk("single_rsp_latency", 32'(acc), LAT);
    chk("single_rsp_result", 32'(bus.rsp_result), 32'(4'b1110));
    chk("single_rsp_carry", 32'(bus.rsp_carry), 1);
    chk("single_rsp_opcode", 32'(bus.rsp_opcode), 32'(3'b010));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp_hold", 32'({bus.rsp_opcode, bus.rsp_result, bus.rsp_carry}), 32'({3'b010, 4'b1110, 1'b1}));
      chk("bp_alu_hold", 32'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 32'({3'b010, 4'b1000, 4'b0000}));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("bp_rsp_cleared", 32'(bus.rsp_valid), 0);
    chk("bp_one_rsp", 32'(nrsp), 1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1;
      bus.req_opcode = 3'(i);
      bus.req_op1 = 4'(i + 3);
      bus.req_op2 = 4'(2 * i + 1);
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("fill_accepted", 32'(acc), DEPTH + 1);
    chk("fill_req_ready_low", 32'(bus.req_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("fill_ready_held_low", 32'(bus.req_ready), 0);
    chk("fill_no_rsp_yet", 32'(nrsp), 1);
    bus.rsp_ready = 1'b1;
    drain();
    chk("fill_rsp_total", 32'(nrsp), 6);
    chk("fill_req_ready_back", 32'(bus.req_ready), 1);
    for (int i = 0; i < 4; i++) push('{opcode: 3'd5, op1: 4'(9 + i), op2: 4'(i)});
    rst = 1'b1;
    #1;
    chk("rst_alu", 32'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
`ifdef ALU_OP_DRIVER_PERF_EN
    chk("rst_op_count", 32'(op_count), 0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = nrsp;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    chk("rst_no_rsp_valid", 32'(seen), 0);
    chk("rst_no_handshake", 32'(nrsp), 32'(base));
    chk("rst_alu_idle", 32'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 0);
    chk("rst_ready_after", 32'(bus.req_ready), 1);
    tp_on = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 8; i++) push('{opcode: 3'(i), op1: 4'(i + 1), op2: 4'(15 - i)});
    drain();
    tp_on = 1'b0;
    chk("tp_issue_count", 32'(n_iss), 8);
    for (int i = 1; i < n_iss; i++) chk("tp_spacing", 32'(iss[i] - iss[i-1]), LAT + 2);
`ifdef ALU_OP_DRIVER_PERF_EN
    chk("tp_op_count", 32'(op_count), 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = nrsp;
    for (int i = 0; i < 256; i++) push('{opcode: 3'(i), op1: 4'(i), op2: 4'(i >> 4)});
    drain();
    chk("wrap_rsp_count", 32'(nrsp - base), 256);
    chk("wrap_op_count", 32'(op_count), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Issue-side companion to the `alu` block. It accepts operation requests (opcode plus two operands) over a valid/ready interface and buffers them in a small FIFO. It drives them one at a time onto the ALU's `OPCODE`/`OP1`/`OP2` inputs, waits the ALU latency, captures the result and returns it over a valid/ready response interface. It sits between a sequencer/testbench stimulus source and the ALU under test, and replaces ad-hoc per-cycle port driving.

## Interface
- `W`, 4: operand and result width.
- `OPC_W`, 3: opcode width.
- `DEPTH`, 4: request FIFO depth; must be a power of 2, at least 2.
- `ALU_LAT`, 1: cycles from ALU input change to valid result; range 1–15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO not full.
- `req_opcode`  in  OPC_W  requested opcode.
- `req_op1`, `req_op2`  in  W  requested operands.
- `alu_opcode`  out  OPC_W  to ALU `OPCODE`.
- `alu_op1`, `alu_op2`  out  W  to ALU `OP1`/`OP2`.
- `alu_result`  in  W  ALU result.
- `alu_carry`  in  1  ALU carry/flag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_opcode`  out  OPC_W  opcode of the returned op, used as a tag.
- `rsp_result`  out  W  captured result.
- `rsp_carry`  out  1  captured carry.
- `op_count`  out  8  issued-op counter; exists only with `ALU_OP_DRIVER_PERF_EN`.

## Operation
- Reset values: all outputs 0 except `req_ready`=1. FIFO is empty and the FSM is in IDLE.
- A request is pushed when `req_valid && req_ready`.
- `req_ready = !full`, registered from the occupancy count. When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head, load `alu_*`, load the wait counter with `ALU_LAT`, and go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, capture `alu_result`/`alu_carry` and the current `alu_opcode` into the `rsp_*` registers, set `rsp_valid`, and go to RESP.
  - RESP: hold all `rsp_*` stable. On `rsp_ready`, clear `rsp_valid` and return to IDLE.
- `alu_*` hold the last issued operation until the next issue; they never return to 0 between ops.
- Pushing and popping in the same cycle on a non-full, non-empty FIFO keeps the count unchanged.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Results are not checked; width is preserved as-is.
- Reset asserted mid-operation: the FIFO is flushed, the FSM goes to IDLE, `rsp_valid`=0 and `alu_*`=0 immediately (asynchronously). Any in-flight op is lost.

## Timing
- Request accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - `alu_*` updated after edge E1.
  - Result sampled at edge E1+`ALU_LAT`.
  - `rsp_valid` high in the cycle after that edge.
- Response handshake at edge H, with the next op already queued: next `alu_*` load at edge H+1.
- Sustained throughput with `rsp_ready` tied high: one op per `ALU_LAT`+2 cycles.
- `req_ready` deasserts in the cycle after the push that fills the FIFO.

## Configuration
- `ALU_OP_DRIVER_PERF_EN` defined:
  - Port `op_count` exists.
  - It increments on every IDLE→WAIT transition, wraps 255→0, and resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - opcode width constant and opcode localparams shared with `alu`;
  - driver FSM state enum (IDLE, WAIT, RESP);
  - packed request struct {opcode, op1, op2}.
- One sub-module: `alu_op_fifo`, a synchronous FIFO with async active-high reset, parameterised by width and `DEPTH`, exposing full/empty/count.

## Test plan
- Single op: push opcode 3'b010, op1 4'b1000, op2 4'b0000; ALU model returns 4'b1110, carry 1.
  - `alu_*` show 010/1000/0000 one cycle after the push.
  - `rsp_valid` rises `ALU_LAT`+1 cycles after the push, with `rsp_result`=1110, `rsp_carry`=1, `rsp_opcode`=010.
- Fill: hold `rsp_ready`=0 and push 6 ops back-to-back.
  - Only `DEPTH`+1=5 are accepted: 4 in the FIFO plus 1 in flight.
  - `req_ready`=0 while full; ops are returned in order once `rsp_ready`=1.
- Backpressure: `rsp_ready` low for 10 cycles during RESP.
  - `rsp_*` stay stable and `alu_*` unchanged; exactly one response per handshake.
- Reset mid-WAIT with 3 ops queued: assert `rst` for 1 cycle.
  - Outputs go to reset values at once; no responses follow; `req_ready`=1.
- Throughput: `ALU_LAT`=3, 8 ops, `rsp_ready`=1.
  - Issues are spaced 5 cycles apart.
  - With `ALU_OP_DRIVER_PERF_EN`, `op_count`=8 at the end.
- Counter wrap (with macro): 256 ops → `op_count`=0.
